reg_wr_arbiter: RTL and testbench

Round-robin arbiter that shares one W-bit register among N requesters. Each requester raises a request with its data. The arbiter grants one requester at a time and writes that requester's data into the shared register. It then returns a one-cycle acknowledge. This is the sequencing block that sits in front of a shared CPU register or write port, so multiple units never write it in the same cycle.

---
 rtl/reg_wr_arbiter.sv | 93 +++++++++
 tb/tb_reg_wr_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_arbiter.sv
// rtl/reg_wr_arbiter.sv - round-robin arbiter serialising writes into one shared register
module reg_wr_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic           busy
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [LW-1:0] last;
    logic [LW-1:0] gidx;
    logic [LW-1:0] sel;
    logic          found;
    logic [N-1:0]  elig;

    // A requester still seeing its ack this cycle is masked so it cannot be written twice
    assign elig = req & ~ack;
    assign busy = (state == GRANT);

    // Pick the first eligible requester scanning cyclically from last+1 round to last
    always_comb begin
        int            idx;
        logic [LW-1:0] idx_l;
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        idx_l = '0;
        for (int k = 1; k <= N; k++) begin
            idx   = (int'(last) + k) % N;
            idx_l = LW'(idx);
            if (!found && elig[idx_l]) begin
                found = 1'b1;
                sel   = idx_l;
            end
        end
    end

    // Grant/write sequencer: IDLE issues a grant, GRANT commits the write or drops a withdrawn request
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= '0;
            ack     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            last    <= LW'(N - 1);
            gidx    <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= N'(1) << sel;
                        gidx  <= sel;
                        state <= GRANT;
                    end else begin
                        grant <= '0;
                    end
                end
                GRANT: begin
                    grant <= '0;
                    state <= IDLE;
                    if (req[gidx]) begin
                        q       <= data[gidx*W +: W];
                        ack     <= N'(1) << gidx;
                        q_valid <= 1'b1;
                        last    <= gidx;
                    end
                end
                default: begin
                    grant <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// tb/tb_reg_wr_arbiter.sv - directed self-checking bench for reg_wr_arbiter
module tb_reg_wr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           busy;

    logic [17:0] obs;
    logic [17:0] exp_v;
    int tests;
    int failed;

    assign obs = {grant, ack, q, q_valid, busy};

    reg_wr_arbiter #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data    (data),
        .grant   (grant),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge and settle past it; outputs sampled and inputs driven here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 4'b1111;
        data  = {N*W{1'b1}};
        for (int e = 0; e < 2; e++) begin
            step();
            exp_v = {4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL reset_edge%0d got %b exp %b", e, obs, exp_v);
            end
        end
        reset = 1'b1;
        req   = '0;
        data  = '0;
        step();
    endtask

    task automatic test_single();
        req = 4'b0100;
        data[2*W +: W] = 8'hA5;
        step();
        exp_v = {4'b0100, 4'b0000, 8'h00, 1'b0, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL single_grant got %b exp %b", obs, exp_v);
        end
        step();
        exp_v = {4'b0000, 4'b0100, 8'hA5, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL single_write got %b exp %b", obs, exp_v);
        end
        req = 4'b0000;
        step();
        exp_v = {4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL single_ack_clear got %b exp %b", obs, exp_v);
        end
    endtask

    task automatic test_all_request();
        do_reset();
        for (int i = 0; i < N; i++) data[i*W +: W] = 8'h10 + 8'(i);
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            step();
            exp_v = {4'(1 << i), 4'b0000, (i == 0) ? 8'h00 : 8'h10 + 8'(i - 1), (i != 0), 1'b1};
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL all_grant%0d got %b exp %b", i, obs, exp_v);
            end
            step();
            exp_v = {4'b0000, 4'(1 << i), 8'h10 + 8'(i), 1'b1, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                failed++;
                $display("FAIL all_write%0d got %b exp %b", i, obs, exp_v);
            end
            req[i] = 1'b0;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] gexp;
        logic [7:0] qexp;
        data[0*W +: W] = 8'h20;
        data[3*W +: W] = 8'h23;
        req = 4'b1001;
        for (int r = 0; r < 4; r++) begin
            gexp = (r % 2 == 0) ? 4'b0001 : 4'b1000;
            qexp = (r % 2 == 0) ? 8'h20 : 8'h23;
            step();
            tests++;
            if (grant !== gexp || ack !== 4'b0000 || busy !== 1'b1) begin
                failed++;
                $display("FAIL fair_grant%0d got grant=%b ack=%b busy=%b exp grant=%b", r, grant, ack, busy, gexp);
            end
            step();
            tests++;
            if (ack !== gexp || q !== qexp || grant !== 4'b0000) begin
                failed++;
                $display("FAIL fair_write%0d got ack=%b q=%h exp ack=%b q=%h", r, ack, q, gexp, qexp);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_withdraw();
        data[1*W +: W] = 8'h3C;
        req = 4'b0010;
        step();
        exp_v = {4'b0010, 4'b0000, 8'h23, 1'b1, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL wd_grant got %b exp %b", obs, exp_v);
        end
        req = 4'b0000;
        step();
        exp_v = {4'b0000, 4'b0000, 8'h23, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL wd_nowrite got %b exp %b", obs, exp_v);
        end
        // last must still be 3, so requester 0 beats requester 3
        req = 4'b1001;
        step();
        tests++;
        if (grant !== 4'b0001) begin
            failed++;
            $display("FAIL wd_last_kept got %b exp %b", grant, 4'b0001);
        end
        req = 4'b0010;
        step();
        tests++;
        if (ack !== 4'b0000 || q !== 8'h23 || grant !== 4'b0000) begin
            failed++;
            $display("FAIL wd_second_withdraw got ack=%b q=%h exp ack=0000 q=23", ack, q);
        end
        step();
        tests++;
        if (grant !== 4'b0010) begin
            failed++;
            $display("FAIL wd_regrant got %b exp %b", grant, 4'b0010);
        end
        step();
        exp_v = {4'b0000, 4'b0010, 8'h3C, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL wd_rewrite got %b exp %b", obs, exp_v);
        end
        req = '0;
        step();
    endtask

    task automatic test_reset_in_grant();
        data[2*W +: W] = 8'h77;
        req = 4'b0100;
        step();
        tests++;
        if (grant !== 4'b0100 || busy !== 1'b1) begin
            failed++;
            $display("FAIL rg_grant got grant=%b busy=%b exp grant=0100 busy=1", grant, busy);
        end
        reset = 1'b0;
        step();
        exp_v = {4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL rg_cleared got %b exp %b", obs, exp_v);
        end
        reset = 1'b1;
        data[0*W +: W] = 8'h55;
        req = 4'b0101;
        step();
        tests++;
        if (grant !== 4'b0001) begin
            failed++;
            $display("FAIL rg_prio got %b exp %b", grant, 4'b0001);
        end
        step();
        exp_v = {4'b0000, 4'b0001, 8'h55, 1'b1, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            failed++;
            $display("FAIL rg_write got %b exp %b", obs, exp_v);
        end
        req = '0;
        step();
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b0;
        req    = '0;
        data   = '0;
        test_reset();
        test_single();
        test_all_request();
        test_fairness();
        test_withdraw();
        test_reset_in_grant();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
